// File: rtl/norm_pkg.sv
// Shared defaults and lane/saturation helpers for the normalizer output collector.
package norm_pkg;

  localparam int COL_DEF     = 16;
  localparam int BW_PSUM_DEF = 11;
  localparam int W_OUT_DEF   = 4;
  localparam int DEPTH_DEF   = 4;

  function automatic int lane_msb(input int lane, input int w);
    return lane * w + w - 1;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizes one signed value: round-half-up arithmetic right shift, then saturation to W_OUT bits.
module requant_sat
  import norm_pkg::*;
#(
  parameter int BW_PSUM = BW_PSUM_DEF,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int SHW     = $clog2(BW_PSUM)
) (
  input  logic        [SHW-1:0]     shift,
  input  logic signed [BW_PSUM-1:0] value,
  output logic signed [W_OUT-1:0]   result
);

  // Wide enough that the rounding constant never wraps, even for shift values beyond BW_PSUM.
  localparam int SW = BW_PSUM + (1 << SHW);
  localparam logic signed [SW-1:0] Q_MAX = SW'(sat_max(W_OUT));
  localparam logic signed [SW-1:0] Q_MIN = SW'(sat_min(W_OUT));

  logic signed [SW-1:0] value_ext;
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  always_comb begin
    value_ext = SW'(value);
    rnd       = '0;
    if (shift != '0) begin
      rnd = SW'(1) << (shift - SHW'(1));
    end
    sum     = value_ext + rnd;
    shifted = sum >>> shift;
    if (shifted > Q_MAX) begin
      result = Q_MAX[W_OUT-1:0];
    end else if (shifted < Q_MIN) begin
      result = Q_MIN[W_OUT-1:0];
    end else begin
      result = shifted[W_OUT-1:0];
    end
  end

endmodule

// File: rtl/norm_out_collector.sv
// Collects paired normalizer lanes into requantized rows and buffers them in a small row FIFO.
module norm_out_collector
  import norm_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int BW_PSUM = BW_PSUM_DEF,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [$clog2(BW_PSUM)-1:0]  shift,
  input  logic                        norm_valid,
  input  logic signed [BW_PSUM-1:0]   psum_norm_1,
  input  logic signed [BW_PSUM-1:0]   psum_norm_2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COL*W_OUT-1:0]        out_row,
  output logic                        overflow,
  output logic [15:0]                 rows_done
);

  localparam int HALF = COL / 2;
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int RW   = COL * W_OUT;
  localparam int SHW  = $clog2(BW_PSUM);

  logic [KW-1:0]             lane_cnt;
  logic [RW-1:0]             stage;
  logic [RW-1:0]             row_full;
  logic signed [W_OUT-1:0]   q_lane [COL];

  logic [RW-1:0]             mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [CW-1:0]             count;

  logic                      last_lane;
  logic                      full;
  logic                      pop;
  logic                      push_req;
  logic                      push_ok;
  logic                      drop;

  // Lower half of the lanes comes from core1, upper half from core2.
  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic signed [BW_PSUM-1:0] src;
    if (i < HALF) begin : g_core1
      assign src = psum_norm_1;
    end else begin : g_core2
      assign src = psum_norm_2;
    end
    requant_sat #(
      .BW_PSUM (BW_PSUM),
      .W_OUT   (W_OUT),
      .SHW     (SHW)
    ) u_requant (
      .shift  (shift),
      .value  (src),
      .result (q_lane[i])
    );
  end

  // The completing pair is merged here so the row can be pushed on the same edge.
  always_comb begin
    row_full = stage;
    for (int i = 0; i < HALF; i++) begin
      if (KW'(i) == lane_cnt) begin
        row_full[lane_msb(i, W_OUT) -: W_OUT]        = q_lane[i];
        row_full[lane_msb(i + HALF, W_OUT) -: W_OUT] = q_lane[i + HALF];
      end
    end
  end

  assign last_lane = (lane_cnt == KW'(HALF - 1));
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push_req  = norm_valid && last_lane;
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && !push_ok;
  assign out_row   = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt  <= '0;
      stage     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rows_done <= '0;
    end else if (clear) begin
      lane_cnt <= '0;
      stage    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (norm_valid) begin
        stage    <= row_full;
        lane_cnt <= last_lane ? '0 : lane_cnt + KW'(1);
      end
      if (push_ok) begin
        wr_ptr    <= wr_ptr + AW'(1);
        rows_done <= rows_done + 16'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Row storage needs no reset: an empty FIFO masks out_row to zero.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push_ok) begin
      mem[wr_ptr] <= row_full;
    end
  end

endmodule

// File: tb/tb_norm_out_collector.sv
// Randomized and directed check of norm_out_collector against a queue-based row model.
module tb_norm_out_collector;

  localparam int COL   = 16;
  localparam int BW    = 11;
  localparam int WO    = 4;
  localparam int DEPTH = 4;
  localparam int HALF  = COL / 2;

  logic                  clk;
  logic                  reset;
  logic                  clear;
  logic [3:0]            shift;
  logic                  norm_valid;
  logic signed [BW-1:0]  psum_norm_1;
  logic signed [BW-1:0]  psum_norm_2;
  logic                  out_valid;
  logic                  out_ready;
  logic [COL*WO-1:0]     out_row;
  logic                  overflow;
  logic [15:0]           rows_done;

  norm_out_collector #(
    .COL     (COL),
    .BW_PSUM (BW),
    .W_OUT   (WO),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .shift       (shift),
    .norm_valid  (norm_valid),
    .psum_norm_1 (psum_norm_1),
    .psum_norm_2 (psum_norm_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .overflow    (overflow),
    .rows_done   (rows_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int                m_k;
  int                m_stage [COL];
  logic [COL*WO-1:0] m_q [$];
  bit                m_ovf;
  int                m_rows;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int lane, input int v);
    logic [WO-1:0] e;
    e = WO'(v);
    chk(tag, 64'(out_row[lane*WO +: WO]), 64'(e));
  endtask

  function automatic int rq(input int x, input int s);
    int y;
    int d;
    int num;
    if (s == 0) begin
      y = x;
    end else begin
      d   = 1 << s;
      num = x + d / 2;
      if (num >= 0) y = num / d;
      else          y = -((-num + d - 1) / d);
    end
    if (y > 7)  y = 7;
    if (y < -8) y = -8;
    return y;
  endfunction

  function automatic logic [COL*WO-1:0] pack_stage();
    logic [COL*WO-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      v = m_stage[i];
      r[i*WO +: WO] = v[WO-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_k = 0;
    for (int i = 0; i < COL; i++) m_stage[i] = 0;
    m_q.delete();
    m_ovf  = 1'b0;
    m_rows = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() > 0));
    chk({tag, ".out_row"}, 64'(out_row), (m_q.size() > 0) ? 64'(m_q[0]) : 64'h0);
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".rows_done"}, 64'(rows_done), 64'(m_rows & 16'hffff));
  endtask

  task automatic step(input bit nv, input int a, input int b, input bit rdy, input bit clr);
    bit pop;
    bit accept;
    logic [COL*WO-1:0] row;
    @(negedge clk);
    norm_valid  = nv;
    psum_norm_1 = a[BW-1:0];
    psum_norm_2 = b[BW-1:0];
    out_ready   = rdy;
    clear       = clr;
    @(posedge clk);
    if (clr) begin
      m_k = 0;
      for (int i = 0; i < COL; i++) m_stage[i] = 0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop    = (m_q.size() > 0) && rdy;
      accept = 1'b0;
      if (nv) begin
        m_stage[m_k]        = rq(a, int'(shift));
        m_stage[HALF + m_k] = rq(b, int'(shift));
        if (m_k == HALF - 1) begin
          row = pack_stage();
          if (m_q.size() < DEPTH || pop) accept = 1'b1;
          else m_ovf = 1'b1;
        end
        m_k = (m_k + 1) % HALF;
      end
      if (pop) void'(m_q.pop_front());
      if (accept) begin
        m_q.push_back(row);
        m_rows++;
      end
    end
    #1;
    check_outputs("cycle");
  endtask

  function automatic int rnd_val();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -1024;
    if (r == 1) return 1023;
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic rand_row(input bit rdy);
    for (int i = 0; i < HALF; i++) step(1'b1, rnd_val(), rnd_val(), rdy, 1'b0);
  endtask

  int base_rows;

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    clear       = 1'b0;
    shift       = 4'd0;
    norm_valid  = 1'b0;
    psum_norm_1 = '0;
    psum_norm_2 = '0;
    out_ready   = 1'b0;
    model_reset();
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'h0);
    chk("reset.out_row", 64'(out_row), 64'h0);
    chk("reset.overflow", 64'(overflow), 64'h0);
    chk("reset.rows_done", 64'(rows_done), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // pairs 1..8 / -1..-8 at shift 0
    for (int i = 0; i < HALF; i++) step(1'b1, i + 1, -(i + 1), 1'b0, 1'b0);
    chk("row1.out_valid", 64'(out_valid), 64'h1);
    for (int i = 0; i < HALF; i++) begin
      chk_lane("row1.lo", i, (i + 1 > 7) ? 7 : i + 1);
      chk_lane("row1.hi", HALF + i, -(i + 1));
    end
    step(1'b0, 0, 0, 1'b1, 1'b0);

    // rounding and saturation at shift 2
    shift = 4'd2;
    step(1'b1, 6, -6, 1'b0, 1'b0);
    step(1'b1, 5, -5, 1'b0, 1'b0);
    step(1'b1, 1000, -1000, 1'b0, 1'b0);
    for (int i = 3; i < HALF; i++) step(1'b1, 0, 0, 1'b0, 1'b0);
    chk_lane("rnd.6", 0, 2);
    chk_lane("rnd.-6", HALF, -1);
    chk_lane("rnd.5", 1, 1);
    chk_lane("rnd.-5", HALF + 1, -1);
    chk_lane("sat.1000", 2, 7);
    chk_lane("sat.-1000", HALF + 2, -8);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    shift = 4'd0;

    // overflow: five rows into a four-row FIFO
    base_rows = int'(rows_done);
    for (int r = 0; r < 5; r++) rand_row(1'b0);
    chk("ovf.flag", 64'(overflow), 64'h1);
    chk("ovf.rows", 64'(16'(int'(rows_done) - base_rows)), 64'd4);
    for (int r = 0; r < 4; r++) step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("ovf.drained", 64'(out_valid), 64'h0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    chk("clear.overflow", 64'(overflow), 64'h0);

    // full FIFO, row completes in the same cycle as a pop
    shift = 4'd3;
    for (int r = 0; r < 4; r++) rand_row(1'b0);
    for (int i = 0; i < HALF - 1; i++) step(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b0);
    chk("popfull.overflow", 64'(overflow), 64'h0);
    for (int r = 0; r < 3; r++) step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("popfull.count4", 64'(out_valid), 64'h1);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("popfull.empty", 64'(out_valid), 64'h0);

    // valid every third cycle
    base_rows = int'(rows_done);
    for (int i = 0; i < HALF; i++) begin
      step(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
      step(1'b0, rnd_val(), rnd_val(), 1'b0, 1'b0);
      step(1'b0, rnd_val(), rnd_val(), 1'b0, 1'b0);
    end
    chk("gap.single_push", 64'(16'(int'(rows_done) - base_rows)), 64'd1);
    step(1'b0, 0, 0, 1'b1, 1'b0);

    // clear mid-row at k=3
    for (int i = 0; i < 3; i++) step(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b1);
    chk("clrmid.empty", 64'(out_valid), 64'h0);
    rand_row(1'b0);
    chk("clrmid.fresh", 64'(out_valid), 64'h1);

    // asynchronous reset mid-row at k=3
    for (int i = 0; i < 3; i++) step(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
    @(negedge clk);
    norm_valid = 1'b0;
    reset      = 1'b1;
    #1;
    model_reset();
    check_outputs("rstmid");
    #2;
    reset = 1'b0;
    rand_row(1'b0);
    chk("rstmid.fresh", 64'(out_valid), 64'h1);

    // random traffic
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0);
      shift = 4'($urandom_range(0, 12));
      for (int n = 0; n < 150; n++) begin
        step(($urandom_range(0, 3) != 0), rnd_val(), rnd_val(),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
